// File: rtl/sram_sp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_sp_arbiter
// Purpose  : Shares one single-port SRAM macro (active-low CEB/WEB, 1-cycle
//            read latency) between a write requester and a read requester.
//            At most one access is granted per cycle. Round-robin arbitration
//            applies when both requesters are eligible. Read data is captured
//            into a 3-entry response FIFO the cycle after the read.
// Ports    : CLK, RSTB (async active-low)
//            wr_valid/wr_ready/wr_addr/wr_data   write request channel
//            rd_valid/rd_ready/rd_addr           read request channel
//            rsp_valid/rsp_ready/rsp_data        read response channel
//            init_done                           block accepts requests
//            sram_ceb/sram_web/sram_a/sram_d/sram_q  macro interface
// Config   : SRAM_ARB_INIT_EN - when defined, a zero-fill sweep of all DEPTH
//            words runs after every reset before requests are accepted.
// Revision : 1.0 - initial release
// ============================================================================
module sram_sp_arbiter #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q
);

    localparam logic       c_PRI_WR    = 1'b0;
    localparam logic       c_PRI_RD    = 1'b1;
    localparam logic [1:0] c_FIFO_LAST = 2'd2;
    localparam logic [2:0] c_CREDITS   = 3'd3;

    // Address width must cover exactly DEPTH words.
    if (ADDR_W != $clog2(DEPTH)) begin : g_cfg_chk
        $error("sram_sp_arbiter: ADDR_W must equal clog2(DEPTH)");
    end

    logic              r_rr_ptr;
    logic              r_inflight;
    logic [1:0]        r_cnt;
    logic [1:0]        r_wptr;
    logic [1:0]        r_rptr;
    logic [DATA_W-1:0] r_fifo [0:2];
    logic              r_init_done;

    logic              w_sweep;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_wr_elig;
    logic              w_rd_elig;
    logic              w_gnt_wr;
    logic              w_gnt_rd;
    logic              w_push;
    logic              w_pop;
    logic              w_ceb;
    logic              w_web;
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_d;

    function automatic logic [1:0] f_next(input logic [1:0] p);
        return (p == c_FIFO_LAST) ? 2'd0 : p + 2'd1;
    endfunction

`ifdef SRAM_ARB_INIT_EN
    localparam logic [0:0]        c_ST_INIT   = 1'b0;
    localparam logic [0:0]        c_ST_RUN    = 1'b1;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_init_addr;

    // Zero-fill sweep: one word per cycle, then hand over to normal traffic.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state     <= c_ST_INIT;
            r_init_addr <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == c_ST_INIT) begin
            if (r_init_addr == c_LAST_ADDR) begin
                r_state     <= c_ST_RUN;
                r_init_done <= 1'b1;
            end else begin
                r_init_addr <= r_init_addr + 1'b1;
            end
        end
    end

    assign w_sweep      = (r_state == c_ST_INIT);
    assign w_sweep_addr = r_init_addr;
`else
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_init_done <= 1'b0;
        end else begin
            r_init_done <= 1'b1;
        end
    end

    assign w_sweep      = 1'b0;
    assign w_sweep_addr = '0;
`endif

    assign init_done = r_init_done;

    // Read credit counts buffered plus in-flight reads from registered state
    // only, so rsp_ready never reaches rd_ready combinationally.
    assign w_wr_elig = wr_valid & r_init_done;
    assign w_rd_elig = rd_valid & r_init_done &
                       (({1'b0, r_cnt} + {2'b00, r_inflight}) < c_CREDITS);

    assign w_gnt_wr = w_wr_elig & (~w_rd_elig | (r_rr_ptr == c_PRI_WR));
    assign w_gnt_rd = w_rd_elig & ~w_gnt_wr;

    assign wr_ready = w_gnt_wr;
    assign rd_ready = w_gnt_rd;

    always_comb begin
        w_ceb = 1'b1;
        w_web = 1'b1;
        w_a   = rd_addr;
        w_d   = wr_data;
        if (w_sweep) begin
            w_ceb = 1'b0;
            w_web = 1'b0;
            w_a   = w_sweep_addr;
            w_d   = '0;
        end else if (w_gnt_wr) begin
            w_ceb = 1'b0;
            w_web = 1'b0;
            w_a   = wr_addr;
        end else if (w_gnt_rd) begin
            w_ceb = 1'b0;
        end
    end

    // Keep the macro deselected for the whole reset window, including the
    // init state that would otherwise already be writing.
    assign sram_ceb = w_ceb | ~RSTB;
    assign sram_web = w_web | ~RSTB;
    assign sram_a   = w_a;
    assign sram_d   = w_d;

    // The read data from the macro is meaningful only in the cycle after a
    // read grant, which is exactly when r_inflight is set.
    assign w_push    = r_inflight;
    assign rsp_valid = (r_cnt != 2'd0);
    assign w_pop     = rsp_valid & rsp_ready;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_rr_ptr   <= c_PRI_WR;
            r_inflight <= 1'b0;
            r_cnt      <= 2'd0;
            r_wptr     <= 2'd0;
            r_rptr     <= 2'd0;
        end else begin
            r_inflight <= w_gnt_rd;
            if (w_wr_elig & w_rd_elig) begin
                r_rr_ptr <= w_gnt_wr ? c_PRI_RD : c_PRI_WR;
            end
            if (w_push) begin
                r_wptr <= f_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_next(r_rptr);
            end
            if (w_push & ~w_pop) begin
                r_cnt <= r_cnt + 2'd1;
            end else if (~w_push & w_pop) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo[r_wptr] <= sram_q;
        end
    end

    assign rsp_data = r_fifo[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_sram_sp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_sp_arbiter
// Purpose  : Self-checking bench for sram_sp_arbiter. Contains a behavioural
//            SRAM macro and a transaction-level reference model (grant order,
//            outstanding-read credit, expected response queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_sp_arbiter;

    localparam int DATA_W = 512;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              CLK = 1'b0;
    logic              RSTB = 1'b1;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_valid = 1'b0;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_data;
    logic              init_done;
    logic              sram_ceb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q = '0;

    sram_sp_arbiter #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .sram_ceb  (sram_ceb),
        .sram_web  (sram_web),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DATA_W-1:0] rnd_word();
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < DATA_W / 32; i++) begin
            w[i*32 +: 32] = $urandom();
        end
        return w;
    endfunction

    // Behavioural macro: Q holds read data only in the cycle after a read,
    // garbage every other cycle.
    logic [DATA_W-1:0] mac_mem [DEPTH];
    always @(posedge CLK) begin
        if (!sram_ceb && !sram_web) begin
            mac_mem[sram_a] <= sram_d;
            sram_q          <= rnd_word();
        end else if (!sram_ceb) begin
            sram_q <= mac_mem[sram_a];
        end else begin
            sram_q <= rnd_word();
        end
    end

    // ---------------- reference model state ----------------
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                known   [DEPTH];
    logic [DATA_W-1:0] exp_data[$];
    bit                exp_chk [$];
    int                exp_cyc [$];
    int                outstanding = 0;
    bit                pri_rd      = 1'b0;
    int                since_rst   = 0;
    int                cyc         = 0;
    int                rd_gnt_seen = 0;
    int                rsp_seen    = 0;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic bit model_done();
`ifdef SRAM_ARB_INIT_EN
        return since_rst >= DEPTH;
`else
        return since_rst >= 1;
`endif
    endfunction

    // One clock cycle: check outputs at negedge against the model, advance
    // the model, then return 1 time unit after the next posedge.
    task automatic step();
        bit done, e_wr, e_rd, g_wr, g_rd, v;
        @(negedge CLK);
        done = model_done();
        e_wr = wr_valid && done;
        e_rd = rd_valid && done && (outstanding < 3);
        g_wr = e_wr && (!e_rd || !pri_rd);
        g_rd = e_rd && !g_wr;
        chk("init_done", DATA_W'(init_done), DATA_W'(done));
        chk("wr_ready", DATA_W'(wr_ready), DATA_W'(g_wr));
        chk("rd_ready", DATA_W'(rd_ready), DATA_W'(g_rd));
        if (rd_ready) rd_gnt_seen++;
        if (rsp_valid) rsp_seen++;
        if (!done) begin
`ifdef SRAM_ARB_INIT_EN
            chk("sweep_ceb", DATA_W'(sram_ceb), '0);
            chk("sweep_web", DATA_W'(sram_web), '0);
            chk("sweep_a", DATA_W'(sram_a), DATA_W'(since_rst));
            chk("sweep_d", sram_d, '0);
            ref_mem[since_rst] = '0;
            known[since_rst]   = 1'b1;
`else
            chk("pre_ceb", DATA_W'(sram_ceb), DATA_W'(1'b1));
            chk("pre_web", DATA_W'(sram_web), DATA_W'(1'b1));
`endif
        end else if (g_wr) begin
            chk("wr_ceb", DATA_W'(sram_ceb), '0);
            chk("wr_web", DATA_W'(sram_web), '0);
            chk("wr_a", DATA_W'(sram_a), DATA_W'(wr_addr));
            chk("wr_d", sram_d, wr_data);
        end else if (g_rd) begin
            chk("rd_ceb", DATA_W'(sram_ceb), '0);
            chk("rd_web", DATA_W'(sram_web), DATA_W'(1'b1));
            chk("rd_a", DATA_W'(sram_a), DATA_W'(rd_addr));
        end else begin
            chk("idle_ceb", DATA_W'(sram_ceb), DATA_W'(1'b1));
            chk("idle_web", DATA_W'(sram_web), DATA_W'(1'b1));
        end
        v = (exp_data.size() > 0) && (exp_cyc[0] <= cyc);
        chk("rsp_valid", DATA_W'(rsp_valid), DATA_W'(v));
        if (v && exp_chk[0]) chk("rsp_data", rsp_data, exp_data[0]);

        if (e_wr && e_rd) pri_rd = g_wr;
        if (g_wr) begin
            ref_mem[wr_addr] = wr_data;
            known[wr_addr]   = 1'b1;
        end
        if (g_rd) begin
            exp_data.push_back(ref_mem[rd_addr]);
            exp_chk.push_back(known[rd_addr]);
            exp_cyc.push_back(cyc + 2);
            outstanding++;
        end
        if (v && rsp_ready) begin
            void'(exp_data.pop_front());
            void'(exp_chk.pop_front());
            void'(exp_cyc.pop_front());
            outstanding--;
        end
        cyc++;
        since_rst++;
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset mid-cycle; outputs must go quiet immediately.
    task automatic do_reset();
        #2 RSTB = 1'b0;
        #1;
        chk("rst_rsp_valid", DATA_W'(rsp_valid), '0);
        chk("rst_ceb", DATA_W'(sram_ceb), DATA_W'(1'b1));
        chk("rst_web", DATA_W'(sram_web), DATA_W'(1'b1));
        chk("rst_wr_ready", DATA_W'(wr_ready), '0);
        chk("rst_rd_ready", DATA_W'(rd_ready), '0);
        repeat (2) @(posedge CLK);
        #1;
        RSTB = 1'b1;
        exp_data.delete();
        exp_chk.delete();
        exp_cyc.delete();
        outstanding = 0;
        pri_rd      = 1'b0;
        since_rst   = 0;
    endtask

    task automatic idle(input int n);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mac_mem[i] = rnd_word();
            ref_mem[i] = '0;
            known[i]   = 1'b0;
        end

        do_reset();
        while (!model_done()) idle(1);

`ifdef SRAM_ARB_INIT_EN
        // Swept memory reads back as zero.
        rd_valid = 1'b1;
        rd_addr  = 5'd17;
        step();
        idle(3);
`endif

        // Contention from a fresh reset: write first, then alternate.
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_addr = ADDR_W'(20 + i);
            wr_data = rnd_word();
            rd_addr = ADDR_W'(24 + i);
            step();
        end
        idle(4);

        // Preload every word so all later reads are checkable.
        wr_valid = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            wr_addr = ADDR_W'(a);
            wr_data = rnd_word();
            step();
        end
        idle(1);

        // Write then read the same address.
        wr_valid = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = {(DATA_W / 8){8'hA5}};
        step();
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 5'd5;
        step();
        idle(3);

        // Credit limit with a stalled consumer, then drain and resume.
        rsp_ready   = 1'b0;
        rd_valid    = 1'b1;
        rd_gnt_seen = 0;
        for (int i = 0; i < 6; i++) begin
            rd_addr = ADDR_W'(10 + i);
            step();
        end
        chk("stall_rd_grants", DATA_W'(rd_gnt_seen), DATA_W'(3));
        rd_valid  = 1'b0;
        rsp_ready = 1'b1;
        repeat (4) step();
        rd_valid = 1'b1;
        rd_addr  = 5'd3;
        step();
        idle(4);

        // Back-to-back reads at full rate.
        rd_valid = 1'b1;
        rsp_seen = 0;
        for (int i = 0; i < 8; i++) begin
            rd_addr = ADDR_W'(i);
            step();
        end
        idle(2);
        chk("b2b_rsp_count", DATA_W'(rsp_seen), DATA_W'(8));
        idle(2);

        // Randomised traffic on a narrow address window to force hazards.
        for (int i = 0; i < 700; i++) begin
            wr_valid  = ($urandom_range(0, 1) == 1);
            rd_valid  = ($urandom_range(0, 2) != 0);
            wr_addr   = ADDR_W'($urandom_range(0, 7));
            rd_addr   = ADDR_W'($urandom_range(0, 7));
            wr_data   = rnd_word();
            rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        rsp_ready = 1'b1;
        idle(6);

        // Reset with two buffered responses and one read in flight.
        rsp_ready = 1'b0;
        rd_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = ADDR_W'(i);
            step();
        end
        rd_valid = 1'b0;
        chk("pre_rst_rsp_valid", DATA_W'(rsp_valid), DATA_W'(1'b1));
        do_reset();
        rsp_ready = 1'b1;
        while (!model_done()) idle(1);
        idle(4);

        // More random traffic after reset; memory contents must persist.
        for (int i = 0; i < 300; i++) begin
            wr_valid  = ($urandom_range(0, 2) == 0);
            rd_valid  = ($urandom_range(0, 1) == 1);
            wr_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
            rd_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
            wr_data   = rnd_word();
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rsp_ready = 1'b1;
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
